// File: rtl/e603_dlm_icb2sram_banked_pkg.sv
// Shared definitions for the banked DLM ICB-to-SRAM bridge.
//   - helpers deriving per-instance geometry from the bus width and bank count
//     (BYTES = DW/8, OFF_W = log2(DW/8), BKW = DW/BANK_NUM)
//   - response-entry layout {rdata, err}: err in bit 0, rdata above it
//   - pointer-width helper for the response FIFO
package e603_dlm_icb2sram_banked_pkg;

  function automatic int unsigned bytes_of(int unsigned dw);
    return dw / 8;
  endfunction

  function automatic int unsigned off_w_of(int unsigned dw);
    return $clog2(dw / 8);
  endfunction

  function automatic int unsigned bkw_of(int unsigned dw, int unsigned bank_num);
    return dw / bank_num;
  endfunction

  function automatic int unsigned ptr_w(int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int unsigned RSP_ERR_LSB  = 0;
  localparam int unsigned RSP_DATA_LSB = 1;

endpackage

// File: rtl/e603_clkgate.sv
// Latch-based integrated clock gate.
//   clk_in    : free-running clock
//   test_mode : forces the output clock on
//   clock_en  : functional enable, captured while clk_in is low
//   clk_out   : gated clock
module e603_clkgate (
  input  logic clk_in,
  input  logic test_mode,
  input  logic clock_en,
  output logic clk_out
);

  logic en_lat;

  // Transparent-low latch keeps the enable glitch-free across the high phase.
  always_latch begin
    if (!clk_in) en_lat = clock_en | test_mode;
  end

  assign clk_out = clk_in & en_lat;

endmodule

// File: rtl/e603_dlm_rsp_fifo.sv
// Flow-through response FIFO for the DLM bridge.
//   clk_i / rst_ni : clock, asynchronous active-low reset
//   push_valid_i   : entry arriving this cycle
//   push_data_i    : arriving entry
//   pop_ready_i    : consumer accepts the head entry
//   out_valid_o    : head entry valid (arriving entry when empty)
//   out_data_o     : head entry
//   count_o        : number of stored entries
module e603_dlm_rsp_fifo
  import e603_dlm_icb2sram_banked_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 65
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_valid_i,
  input  logic [W-1:0]               push_data_i,
  input  logic                       pop_ready_i,
  output logic                       out_valid_o,
  output logic [W-1:0]               out_data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PW = ptr_w(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          empty, full, store, pop_mem;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty       = (cnt_q == '0);
  assign full        = (cnt_q == CW'(DEPTH));
  assign out_valid_o = ~empty | push_valid_i;
  assign out_data_o  = empty ? push_data_i : mem_q[rd_q];
  assign count_o     = cnt_q;

  // An arrival into an empty FIFO that is consumed at once is never stored.
  assign store   = push_valid_i & ~(empty & pop_ready_i);
  assign pop_mem = ~empty & pop_ready_i;

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (store)   wr_d = ptr_inc(wr_q);
    if (pop_mem) rd_d = ptr_inc(rd_q);
    if (store && !pop_mem)      cnt_d = cnt_q + 1'b1;
    else if (!store && pop_mem) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      assert (!(push_valid_i && full));
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (store) mem_q[wr_q] <= push_data_i;
  end

endmodule

// File: rtl/e603_dlm_icb2sram_banked.sv
// ICB slave to banked single-port SRAM bridge for the data local memory.
//   clk, rst_n          : core clock, asynchronous active-low reset
//   clkgate_bypass      : forces all bank clocks on
//   stall               : blocks command acceptance
//   cmd_*               : ICB command channel (valid/ready/read/addr/wdata/wmask/size/dmode)
//   rsp_*               : ICB response channel (valid/ready/rdata/err)
//   ram_cs/we/addr/dmode: per-bank SRAM controls
//   ram_wem/din/dout    : byte enables and data, bank b uses slice b
//   ram_clk             : per-bank gated clocks
module e603_dlm_icb2sram_banked
  import e603_dlm_icb2sram_banked_pkg::*;
#(
  parameter int unsigned AW       = 16,
  parameter int unsigned DW       = 64,
  parameter int unsigned BANK_NUM = 2,
  parameter int unsigned RAM_AW   = 13,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned OUTST    = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clkgate_bypass,
  input  logic                       stall,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_read,
  input  logic [AW-1:0]              cmd_addr,
  input  logic [DW-1:0]              cmd_wdata,
  input  logic [DW/8-1:0]            cmd_wmask,
  input  logic [2:0]                 cmd_size,
  input  logic                       cmd_dmode,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DW-1:0]              rsp_rdata,
  output logic                       rsp_err,
  output logic [BANK_NUM-1:0]        ram_cs,
  output logic [BANK_NUM-1:0]        ram_we,
  output logic [BANK_NUM*RAM_AW-1:0] ram_addr,
  output logic [DW/8-1:0]            ram_wem,
  output logic [DW-1:0]              ram_din,
  input  logic [DW-1:0]              ram_dout,
  output logic [BANK_NUM-1:0]        ram_dmode,
  output logic [BANK_NUM-1:0]        ram_clk
);

  localparam int unsigned BYTES = bytes_of(DW);
  localparam int unsigned OFF_W = off_w_of(DW);
  localparam int unsigned BKW   = bkw_of(DW, BANK_NUM);
  localparam int unsigned BKB   = BKW / 8;
  localparam int unsigned CW    = $clog2(OUTST + 1);
  localparam int unsigned EW    = DW + 1;

  logic [CW-1:0]     cnt_q, cnt_d;
  logic              hsk, rsp_hsk, err_c;
  logic [BYTES-1:0]  rd_lanes, lanes;
  logic [RD_LAT-1:0] pv_q, pv_d, pe_q, pe_d, pr_q, pr_d;
  logic              push;
  logic [EW-1:0]     push_entry, head_entry;
  logic [CW-1:0]     fifo_cnt;

  // Credit counter: a response pop only frees a slot from the next cycle on.
  assign cmd_ready = rst_n & ~stall & (cnt_q < CW'(OUTST));
  assign hsk       = cmd_valid & cmd_ready;
  assign rsp_hsk   = rsp_valid & rsp_ready;

  always_comb begin
    cnt_d = cnt_q;
    if (hsk && !rsp_hsk)      cnt_d = cnt_q + 1'b1;
    else if (!hsk && rsp_hsk) cnt_d = cnt_q - 1'b1;
  end

  // Alignment check and the byte lanes a read touches.
  always_comb begin
    err_c    = 1'b0;
    rd_lanes = '0;
    if (cmd_size > 3'(OFF_W)) begin
      err_c = 1'b1;
    end else begin
      for (int unsigned i = 0; i < OFF_W; i++) begin
        if ((i < 32'(cmd_size)) && cmd_addr[i]) err_c = 1'b1;
      end
      for (int unsigned l = 0; l < BYTES; l++) begin
        if ((l >= 32'(cmd_addr[OFF_W-1:0])) &&
            (l < 32'(cmd_addr[OFF_W-1:0]) + (32'd1 << cmd_size)))
          rd_lanes[l] = 1'b1;
      end
    end
  end

  assign lanes = cmd_read ? rd_lanes : cmd_wmask;

  always_comb begin
    ram_cs = '0;
    for (int unsigned b = 0; b < BANK_NUM; b++) begin
      ram_cs[b] = hsk & ~err_c & (|lanes[b*BKB +: BKB]);
    end
  end

  assign ram_addr  = {BANK_NUM{cmd_addr[RAM_AW+OFF_W-1:OFF_W]}};
  assign ram_we    = {BANK_NUM{~cmd_read}};
  assign ram_wem   = cmd_wmask & {BYTES{~cmd_read}};
  assign ram_din   = cmd_wdata;
  assign ram_dmode = {BANK_NUM{cmd_dmode}};

  for (genvar gb = 0; gb < BANK_NUM; gb++) begin : g_cg
    e603_clkgate u_cg (
      .clk_in   (clk),
      .test_mode(clkgate_bypass),
      .clock_en (ram_cs[gb]),
      .clk_out  (ram_clk[gb])
    );
  end

  // Latency pipeline carrying {valid, err, is_read} alongside the SRAM access.
  always_comb begin
    pv_d    = pv_q;
    pe_d    = pe_q;
    pr_d    = pr_q;
    pv_d[0] = hsk;
    pe_d[0] = err_c;
    pr_d[0] = cmd_read;
    for (int unsigned i = 1; i < RD_LAT; i++) begin
      pv_d[i] = pv_q[i-1];
      pe_d[i] = pe_q[i-1];
      pr_d[i] = pr_q[i-1];
    end
  end

  assign push = pv_q[RD_LAT-1];
  assign push_entry = {((pr_q[RD_LAT-1] & ~pe_q[RD_LAT-1]) ? ram_dout : {DW{1'b0}}),
                       pe_q[RD_LAT-1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      pv_q  <= '0;
      pe_q  <= '0;
      pr_q  <= '0;
    end else begin
      assert (fifo_cnt <= cnt_q);
      cnt_q <= cnt_d;
      pv_q  <= pv_d;
      pe_q  <= pe_d;
      pr_q  <= pr_d;
    end
  end

  e603_dlm_rsp_fifo #(
    .DEPTH(OUTST),
    .W    (EW)
  ) u_rsp_fifo (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .push_valid_i(push),
    .push_data_i (push_entry),
    .pop_ready_i (rsp_ready),
    .out_valid_o (rsp_valid),
    .out_data_o  (head_entry),
    .count_o     (fifo_cnt)
  );

  assign rsp_err   = head_entry[RSP_ERR_LSB];
  assign rsp_rdata = head_entry[RSP_DATA_LSB +: DW];

endmodule

// File: doc/e603_dlm_icb2sram_banked.md
Name: e603_dlm_icb2sram_banked

Overview:
Parametrised ICB-slave-to-SRAM bridge for the data local memory (DLM). It splits one DW-bit ICB port across BANK_NUM equal-width single-port SRAM banks, with per-bank chip-select and gated clock. It supports configurable SRAM read latency and up to OUTST outstanding commands through a flow-through response FIFO. It flags misaligned accesses as bus errors without touching the SRAM.

Parameters:
AW, 16, ICB address width (byte address)
DW, 64, ICB data width; power of 2, >= 32
BANK_NUM, 2, number of SRAM banks; power of 2; bank width BKW = DW/BANK_NUM >= 8
RAM_AW, 13, SRAM word-address width; requires RAM_AW + log2(DW/8) <= AW
RD_LAT, 1, SRAM read latency in cycles; legal values 1 or 2
OUTST, 2, maximum in-flight plus buffered responses; also the response FIFO depth; >= RD_LAT

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
clkgate_bypass  in  1  forces bank clocks ungated (DFT)
stall  in  1  blocks command acceptance this cycle
cmd_valid  in  1  ICB command valid
cmd_ready  out  1  ICB command ready
cmd_read  in  1  1 = read, 0 = write
cmd_addr  in  AW  byte address
cmd_wdata  in  DW  write data
cmd_wmask  in  DW/8  byte write mask
cmd_size  in  3  log2 of access bytes
cmd_dmode  in  1  debug-mode attribute, passed to the SRAMs
rsp_valid  out  1  response valid
rsp_ready  in  1  response ready
rsp_rdata  out  DW  read data (0 for writes and errors)
rsp_err  out  1  error response
ram_cs  out  BANK_NUM  per-bank chip select
ram_we  out  BANK_NUM  per-bank write enable
ram_addr  out  BANK_NUM*RAM_AW  per-bank word address
ram_wem  out  DW/8  byte write enables, bank b uses slice b
ram_din  out  DW  write data, bank b uses slice b
ram_dout  in  DW  read data, bank b uses slice b
ram_dmode  out  BANK_NUM  per-bank dmode
ram_clk  out  BANK_NUM  gated bank clocks

Behaviour:
- Reset (rst_n low, async): outstanding counter = 0, FIFO empty, latency shift register cleared. rsp_valid = 0; all ram_cs = 0; cmd_ready = 0 while in reset.
- Credit: cnt = commands accepted and not yet response-handshaked.
- cmd_ready = ~stall & (cnt < OUTST). A response handshake in the same cycle does not free a credit until the next cycle.
- hsk = cmd_valid & cmd_ready. cnt increments on hsk, decrements on rsp handshake; both in one cycle leaves cnt unchanged.
- Misalignment: cmd_addr[size-1:0] != 0, or size > log2(DW/8). Sets err_c = 1, and all ram_cs = 0 for that command.
- Bank select: bank b covers byte lanes [b*BKW/8, (b+1)*BKW/8).
  - Read: ram_cs[b] = hsk & ~err_c & (lane range of [addr offset, offset + 2^size) overlaps bank b).
  - Write: ram_cs[b] = hsk & ~err_c & |wmask slice b.
- ram_addr (all banks) = cmd_addr[RAM_AW+log2(DW/8)-1 : log2(DW/8)].
- ram_we[b] = ~cmd_read; ram_wem = wmask gated by ~cmd_read; ram_din = cmd_wdata; ram_dmode[b] = cmd_dmode.
- All ram outputs are combinational from the command.
- ram_clk[b] comes from an e603_clkgate instance enabled by ram_cs[b]; clkgate_bypass forces the clock on.
- Pipeline: {err, is_read} travels down an RD_LAT-deep valid shift register. At stage RD_LAT the entry is pushed into the FIFO with data = is_read & ~err ? ram_dout : 0.
- ram_dout is sampled exactly RD_LAT cycles after the cs cycle. Banks that were not selected contribute their dout unmodified; the requester ignores those lanes.
- FIFO is flow-through: when it is empty, the arriving entry drives rsp_valid and rsp_* combinationally in that cycle. Minimum latency is therefore RD_LAT (cmd hsk at T gives rsp_valid at T+RD_LAT).
- Push and pop in the same cycle are legal at any occupancy. The credit scheme guarantees no overflow; push while full is an assertion failure.
- With rsp_ready held low, responses stay stable in order. The command port stalls once cnt reaches OUTST.
- Responses are always returned in order. stall never drops in-flight responses.
- Reset mid-operation: all in-flight and buffered responses are discarded.

Decomposition:
- Shared package holds:
  - derived constants: BKW, BYTES = DW/8, OFF_W = log2(DW/8);
  - the response-entry layout {rdata, err}.
- One sub-module: e603_dlm_rsp_fifo (flow-through, depth OUTST, width DW+1, parametric), which also owns the occupancy count.
- Clock gating reuses the existing e603_clkgate.

Test Plan:
- DW=64, BANK_NUM=2, RD_LAT=1: 8-byte read at 0x0010 -> ram_cs=2'b11, ram_addr=2 both banks; rsp_valid next cycle with rdata={dout1,dout0}, err=0.
- 4-byte write at 0x000C, wmask=0xF0 -> only ram_cs[1]=1, ram_wem=0xF0, ram_we=2'b11; write response err=0, rdata=0 after 1 cycle.
- 4-byte read at 0x0006 (misaligned) -> ram_cs=0, no clock toggle; rsp_err=1, rdata=0 at T+1.
- OUTST=2, RD_LAT=2, rsp_ready=0, back-to-back reads -> two accepted, cmd_ready=0 on the third; set rsp_ready=1 -> responses pop in order, cmd_ready returns the cycle after the first pop.
- BANK_NUM=4, DW=64: 2-byte read at 0x0004 -> only ram_cs[2]=1. stall=1 with cmd_valid=1 -> cmd_ready=0 and no ram_cs.
- Assert rst_n low with 2 responses pending -> rsp_valid=0 and cnt=0 immediately; after release the first command is accepted at once.
